seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the single-cycle ALU of the single-cycle MIPS datapath. It performs AND/OR/ADD/SUB/SLT in one cycle and a full-width multiply iteratively, using a Start/Busy/Done handshake. It optionally performs unsigned divide/remainder. It sits between the register file read ports and the writeback mux, and the controller stalls on Busy.

## Interface
Parameters:
- ALU_Width, 32, operand/result width (≥ 4)
- ALU_Control_Signal, 3, opcode width (fixed encoding below)

Ports:
- CLK  input  1  single clock, rising edge
- RST  input  1  reset, synchronous, active-high
- Start  input  1  request; accepted only when Busy=0
- SrcA  input  ALU_Width  operand A, latched on accept
- SrcB  input  ALU_Width  operand B, latched on accept
- ALUControl  input  ALU_Control_Signal  opcode, latched on accept
- Busy  output  1  operation in flight; Start ignored
- Done  output  1  one-cycle pulse, result valid
- ALUResult  output  ALU_Width  registered result, held until next Done
- ResultHi  output  ALU_Width  upper product half (MUL), else 0
- Zero  output  1  registered zero flag

## Operation
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD (wraps mod 2^W)
  - 100 SUB (wraps)
  - 101 MUL, unsigned, 2W-bit product: low half → ALUResult, high half → ResultHi
  - 110 SLT, signed two's-complement; result 1 or 0
  - 011 DIVU
  - 111 REMU
- FSM states:
  - IDLE: accept Start. Single-cycle ops → DONE. MUL → MUL_ITER. 011/111 → DIV_ITER (macro on) or DONE (macro off).
  - MUL_ITER: shift-add, one multiplier bit per cycle, W iterations → DONE.
  - DIV_ITER: restoring divide, one quotient bit per cycle, W iterations → DONE.
  - DONE: Done=1 and outputs updated → IDLE.
- Busy = (state ≠ IDLE), including DONE. Start during DONE is ignored, so back-to-back issue is one op per 2 cycles minimum.
- Zero = (ALUResult == 0), registered with the result. Exception: opcodes 011/111 with the macro off force Zero=0.
- Divide by zero: quotient = all ones, remainder = SrcA, latency unchanged.
- Reset (any state, mid-op included): next edge gives state=IDLE, Busy=0, Done=0, ALUResult=0, ResultHi=0, Zero=0; the partial operation is discarded.
- Inputs are not sampled after accept; changing them while Busy has no effect.

## Timing
- Accept at edge N (Start=1, Busy=0).
- Single-cycle ops: Done=1 in cycle N+1.
- MUL/DIVU/REMU: Done=1 in cycle N+W+1 (N+33 for W=32).
- Outputs change only on the Done edge. Between operations they hold the last values, or reset values after reset.
- No combinational path from inputs to outputs.

## Configuration
- DIVIDER_EN defined: DIVU/REMU are implemented by the iterative divider with W+1-cycle latency.
- DIVIDER_EN undefined: no divider logic. Opcodes 011/111 complete in 1 cycle with ALUResult=0, ResultHi=0, Zero=0.

## Structure
- Package alu_pkg holds:
  - opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT, ALU_DIVU, ALU_REMU)
  - FSM state typedef (IDLE, MUL_ITER, DIV_ITER, DONE)
- Iteration counter width is $clog2(ALU_Width+1).
- One sub-module, seq_divider (restoring, W iterations, start/done). It is instantiated only under DIVIDER_EN. The multiplier stays inline.

## Test plan
- ADD 7+5 accepted at cycle 0 → Done cycle 1, ALUResult=12, Zero=0. Then SUB 5−5 → ALUResult=0, Zero=1. ADD 0xFFFFFFFF+1 → 0, Zero=1.
- SLT −1 vs 1 → 1. SLT 1 vs −1 → 0. SLT 3 vs 3 → 0, Zero=1.
- MUL 0x00010000×0x00010000 → Done cycle N+33, ALUResult=0, ResultHi=1. MUL 0xFFFFFFFF×2 → 0xFFFFFFFE / 0x1.
- While a MUL is Busy, pulse Start with ADD at cycle N+5 → ignored; the MUL result is unchanged, and a single Done occurs.
- DIVIDER_EN on: DIVU 100/7 → 14; REMU → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9. DIVIDER_EN off: opcode 011 → Done N+1, ALUResult=0, Zero=0.
- Assert RST at cycle N+10 of a MUL → next cycle Busy=0, Done=0, ALUResult=0, ResultHi=0. A fresh ADD then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for seq_alu and its divider.
// DIVU/REMU hardware is present only when DIVIDER_EN is defined.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_DIVU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2,
        DONE     = 2'd3
    } alu_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, W iterations after i_start.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module seq_divider
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic [W:0]    w_shift;
    logic [W+1:0]  w_trial;

    // Trial is one bit wider than the shifted remainder so its sign bit is exact.
    always_comb begin
        w_shift = {r_rem, r_quo[W-1]};
        w_trial = {1'b0, w_shift} - {2'b00, r_div};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (!w_trial[W+1]) begin
                r_rem <= w_trial[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign o_done      = r_busy && (r_cnt == LAST);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle logic/arith, iterative shift-add MUL, optional iterative DIVU/REMU.
// Define DIVIDER_EN to build the divider; otherwise opcodes 011/111 return 0 with Zero=0.
module seq_alu
    import alu_pkg::*;
#(
    parameter int ALU_Width          = 32,
    parameter int ALU_Control_Signal = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Start,
    input  logic [ALU_Width-1:0]          SrcA,
    input  logic [ALU_Width-1:0]          SrcB,
    input  logic [ALU_Control_Signal-1:0] ALUControl,
    output logic                          Busy,
    output logic                          Done,
    output logic [ALU_Width-1:0]          ALUResult,
    output logic [ALU_Width-1:0]          ResultHi,
    output logic                          Zero
);

    localparam int W  = ALU_Width;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    alu_state_t                    r_state;
    logic [W-1:0]                  r_a;
    logic [W-1:0]                  r_b;
    logic [ALU_Control_Signal-1:0] r_op;
    logic [CW-1:0]                 r_cnt;
    logic [2*W-1:0]                r_prod;
    logic [W:0]                    w_madd;
    logic [W-1:0]                  w_lo;
    logic [W-1:0]                  w_hi;
    logic                          w_zero_en;
    logic                          w_zero;

`ifdef DIVIDER_EN
    logic         w_accept;
    logic         w_is_div;
    logic         w_div_done;
    logic [W-1:0] w_quo;
    logic [W-1:0] w_rem;

    assign w_accept = Start && (r_state == IDLE);
    assign w_is_div = (ALUControl == ALU_DIVU) || (ALUControl == ALU_REMU);

    seq_divider #(.W(W)) u_div (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_start     (w_accept && w_is_div),
        .i_dividend  (SrcA),
        .i_divisor   (SrcB),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );
`endif

    assign Busy = (r_state != IDLE);

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
    always_comb begin
        w_madd = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : '0);
    end

    always_comb begin
        w_lo      = '0;
        w_hi      = '0;
        w_zero_en = 1'b1;
        case (r_op)
            ALU_AND: w_lo = r_a & r_b;
            ALU_OR:  w_lo = r_a | r_b;
            ALU_ADD: w_lo = r_a + r_b;
            ALU_SUB: w_lo = r_a - r_b;
            ALU_SLT: w_lo = {{(W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            ALU_MUL: begin
                w_lo = r_prod[W-1:0];
                w_hi = r_prod[2*W-1:W];
            end
`ifdef DIVIDER_EN
            ALU_DIVU: w_lo = w_quo;
            ALU_REMU: w_lo = w_rem;
`else
            ALU_DIVU, ALU_REMU: w_zero_en = 1'b0;
`endif
            default: ;
        endcase
        w_zero = w_zero_en && (w_lo == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_cnt     <= '0;
            r_prod    <= '0;
            Done      <= 1'b0;
            ALUResult <= '0;
            ResultHi  <= '0;
            Zero      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a    <= SrcA;
                        r_b    <= SrcB;
                        r_op   <= ALUControl;
                        r_cnt  <= '0;
                        r_prod <= {{W{1'b0}}, SrcB};
                        if (ALUControl == ALU_MUL) begin
                            r_state <= MUL_ITER;
`ifdef DIVIDER_EN
                        end else if (w_is_div) begin
                            r_state <= DIV_ITER;
`endif
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                MUL_ITER: begin
                    r_prod <= {w_madd, r_prod[W-1:1]};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                    end
                end
                DIV_ITER: begin
`ifdef DIVIDER_EN
                    if (w_div_done) begin
                        r_state <= DONE;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                DONE: begin
                    ALUResult <= w_lo;
                    ResultHi  <= w_hi;
                    Zero      <= w_zero;
                    Done      <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed plan plus random ops against an arithmetic model.
// Build with and without DIVIDER_EN; expectations follow the macro.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        int          acc;
        int          due;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [2:0]  ALUControl = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] ALUResult;
    logic [31:0] ResultHi;
    logic        Zero;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last = '{lo: 32'h0, hi: 32'h0, z: 1'b0, acc: 0, due: 0};

    seq_alu #(.ALU_Width(32), .ALU_Control_Signal(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .Busy       (Busy),
        .Done       (Done),
        .ALUResult  (ALUResult),
        .ResultHi   (ResultHi),
        .Zero       (Zero)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi, output logic z);
        longint unsigned p;
        logic zen;
        lo  = '0;
        hi  = '0;
        zen = 1'b1;
        p   = 64'(a) * 64'(b);
        case (op)
            ALU_AND: lo = a & b;
            ALU_OR:  lo = a | b;
            ALU_ADD: lo = a + b;
            ALU_SUB: lo = a - b;
            ALU_SLT: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_MUL: begin
                lo = p[31:0];
                hi = p[63:32];
            end
`ifdef DIVIDER_EN
            ALU_DIVU: lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: lo = (b == 0) ? a : a % b;
`else
            ALU_DIVU, ALU_REMU: zen = 1'b0;
`endif
            default: ;
        endcase
        z = zen && (lo == 0);
    endfunction

    function automatic int latency(input logic [2:0] op);
`ifdef DIVIDER_EN
        if (op == ALU_DIVU || op == ALU_REMU) return 33;
`endif
        return (op == ALU_MUL) ? 33 : 1;
    endfunction

    // Called at posedge+2; waits for Busy=0, drives one request, scrambles inputs after accept.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_lit, input logic [31:0] llo, input logic [31:0] lhi,
                         input logic lz, output int acc);
        exp_t e;
        int n = 0;
        while (Busy && n < 200) begin
            @(posedge CLK); #2;
            n++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout cyc=%0d got=busy want=idle", cyc);
        end
        ALUControl = op;
        SrcA = a;
        SrcB = b;
        Start = 1'b1;
        acc = cyc + 1;
        model(op, a, b, e.lo, e.hi, e.z);
        if (use_lit) begin
            chk("model_lo", e.lo, llo);
            chk("model_hi", e.hi, lhi);
            chk("model_z", {31'b0, e.z}, {31'b0, lz});
            e.lo = llo;
            e.hi = lhi;
            e.z  = lz;
        end
        e.acc = acc;
        e.due = acc + latency(op);
        q.push_back(e);
        @(posedge CLK); #2;
        Start = 1'b0;
        SrcA = $urandom;
        SrcB = $urandom;
        ALUControl = 3'($urandom);
    endtask

    // Compare process: Done/Busy timing and held-or-updated outputs every cycle out of reset.
    always @(negedge CLK) begin
        if (!RST) begin
            logic done_exp;
            logic busy_exp;
            done_exp = (q.size() > 0) && (q[0].due == cyc);
            busy_exp = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].due);
            chk("done", {31'b0, Done}, {31'b0, done_exp});
            chk("busy", {31'b0, Busy}, {31'b0, busy_exp});
            if (done_exp) last = q.pop_front();
            chk("result", ALUResult, last.lo);
            chk("result_hi", ResultHi, last.hi);
            chk("zero", {31'b0, Zero}, {31'b0, last.z});
        end
    end

    initial begin
        int acc;
        logic [31:0] ra, rb;
        logic [2:0] rop;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #2;

        issue(ALU_ADD, 32'd7, 32'd5, 1'b1, 32'd12, 32'd0, 1'b0, acc);
        issue(ALU_SUB, 32'd5, 32'd5, 1'b1, 32'd0, 32'd0, 1'b1, acc);
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 32'd0, 1'b1, acc);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 32'd0, 1'b0, acc);
        issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, 1'b1, acc);
        issue(ALU_SLT, 32'd3, 32'd3, 1'b1, 32'd0, 32'd0, 1'b1, acc);
        issue(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 32'd0, 1'b0, acc);
        issue(ALU_OR, 32'hF000_0000, 32'h0000_000F, 1'b1, 32'hF000_000F, 32'd0, 1'b0, acc);

        // MUL with a stray ADD request mid-flight that must be ignored.
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 32'd1, 1'b1, acc);
        while (cyc < acc + 4) begin @(posedge CLK); #2; end
        ALUControl = ALU_ADD;
        SrcA = 32'd1;
        SrcB = 32'd2;
        Start = 1'b1;
        @(posedge CLK); #2;
        Start = 1'b0;

        issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 32'd1, 1'b0, acc);
`ifdef DIVIDER_EN
        issue(ALU_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 32'd0, 1'b0, acc);
        issue(ALU_REMU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd0, 1'b0, acc);
        issue(ALU_DIVU, 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, acc);
        issue(ALU_REMU, 32'd9, 32'd0, 1'b1, 32'd9, 32'd0, 1'b0, acc);
        issue(ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'd0, 1'b0, acc);
`else
        issue(ALU_DIVU, 32'd100, 32'd7, 1'b1, 32'd0, 32'd0, 1'b0, acc);
        issue(ALU_REMU, 32'd9, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, acc);
`endif
        issue(ALU_MUL, 32'h8000_0001, 32'h0000_0003, 1'b1, 32'h8000_0003, 32'd1, 1'b0, acc);

        // Reset in the middle of a MUL: partial op discarded, outputs cleared.
        issue(ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '0, '0, 1'b0, acc);
        while (cyc < acc + 9) begin @(posedge CLK); #2; end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        q.delete();
        last = '{lo: 32'h0, hi: 32'h0, z: 1'b0, acc: 0, due: 0};
        #1;
        issue(ALU_ADD, 32'h10, 32'h20, 1'b1, 32'h30, 32'd0, 1'b0, acc);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: ra = '1;
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(rop, ra, rb, 1'b0, '0, '0, 1'b0, acc);
        end

        for (int n = 0; n < 200 && q.size() > 0; n++) @(posedge CLK);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d got=%0d want=0", cyc, q.size());
        end
        repeat (3) @(posedge CLK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
